// File: rtl/frogger_pkg.sv
// Shared pixel/raster definitions for the frogger video path.
// Every colour and coordinate type used by the compositor comes from here.
package frogger_pkg;

  localparam int COLOR_W  = 6;
  localparam int COORD_W  = 10;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  typedef logic [COLOR_W-1:0] pixel_t;
  typedef logic [COORD_W-1:0] coord_t;

  localparam pixel_t TRANSPARENT = 6'b000000;
  localparam pixel_t BLACK       = 6'b000000;

endpackage

// File: rtl/layer_compositor_if.sv
// Pixel-side bus of the layer compositor: raster position, syncs and layer data in;
// composited pixel, delayed syncs and the per-frame collision report out.
interface layer_compositor_if #(
  parameter int NUM_LAYERS = 4,
  parameter int COLOR_W    = frogger_pkg::COLOR_W
);
  import frogger_pkg::*;

  coord_t                          colPos;
  coord_t                          rowPos;
  logic                            hsync_in;
  logic                            vsync_in;
  logic [NUM_LAYERS*COLOR_W-1:0]   layer_color;
  logic [NUM_LAYERS-1:0]           layer_enable;
  logic [NUM_LAYERS-1:0]           mask_a;
  logic [NUM_LAYERS-1:0]           mask_b;

  logic [COLOR_W-1:0]              color;
  logic                            HSYNC;
  logic                            VSYNC;
  logic                            collision;
  coord_t                          collision_x;
  coord_t                          collision_y;
  logic                            frame_done;

  modport master (
    output colPos, rowPos, hsync_in, vsync_in,
    output layer_color, layer_enable, mask_a, mask_b,
    input  color, HSYNC, VSYNC, collision, collision_x, collision_y, frame_done
  );

  modport slave (
    input  colPos, rowPos, hsync_in, vsync_in,
    input  layer_color, layer_enable, mask_a, mask_b,
    output color, HSYNC, VSYNC, collision, collision_x, collision_y, frame_done
  );

endinterface

// File: rtl/prio_select.sv
// Combinational priority select: the opaque layer with the lowest index wins,
// the background colour is returned when no layer is opaque.
module prio_select #(
  parameter int NUM_LAYERS = 4,
  parameter int COLOR_W    = frogger_pkg::COLOR_W
) (
  input  logic [NUM_LAYERS-1:0]         opq_s,
  input  logic [NUM_LAYERS*COLOR_W-1:0] colors_s,
  input  logic [COLOR_W-1:0]            bg_s,
  output logic [COLOR_W-1:0]            pixel_s
);

  // Walk from the lowest priority upward so layer 0 is the final writer.
  always_comb begin
    pixel_s = bg_s;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      pixel_s = opq_s[i] ? colors_s[i*COLOR_W +: COLOR_W] : pixel_s;
    end
  end

endmodule

// File: rtl/layer_compositor.sv
// Two-stage layer compositor: priority-merges the colour layers into one VGA pixel,
// delays the syncs to match and reports the first group-A/group-B overlap of each frame.
module layer_compositor #(
  parameter int                 NUM_LAYERS  = 4,
  parameter int                 COLOR_W     = frogger_pkg::COLOR_W,
  parameter logic [COLOR_W-1:0] TRANSPARENT = frogger_pkg::TRANSPARENT,
  parameter logic [COLOR_W-1:0] BG_COLOR    = frogger_pkg::BLACK,
  parameter int                 H_ACTIVE    = frogger_pkg::H_ACTIVE,
  parameter int                 V_ACTIVE    = frogger_pkg::V_ACTIVE
) (
  input logic               clk,
  input logic               reset,
  layer_compositor_if.slave bus
);
  import frogger_pkg::*;

  localparam coord_t             H_LIM_C = coord_t'(H_ACTIVE);
  localparam coord_t             V_LIM_C = coord_t'(V_ACTIVE);
  localparam logic [COLOR_W-1:0] BLANK_C = COLOR_W'(BLACK);

  logic [NUM_LAYERS-1:0]         opq_s;
  logic                          active_s;
  logic                          grp_a_s;
  logic                          grp_b_s;

  coord_t                        col1_r;
  coord_t                        row1_r;
  logic                          hs1_r;
  logic                          vs1_r;
  logic [NUM_LAYERS*COLOR_W-1:0] lc1_r;
  logic [NUM_LAYERS-1:0]         opq1_r;
  logic                          act1_r;
  logic                          grp_a1_r;
  logic                          grp_b1_r;

  logic                          hit_s;
  logic                          frame_end_s;
  logic [COLOR_W-1:0]            sel_s;

  logic                          sticky_r;
  coord_t                        pend_x_r;
  coord_t                        pend_y_r;

  logic [COLOR_W-1:0]            color_r;
  logic                          hs2_r;
  logic                          vs2_r;
  logic                          collision_r;
  logic                          frame_done_r;
  coord_t                        coll_x_r;
  coord_t                        coll_y_r;

  // A layer is opaque when it is enabled and not showing the transparent key.
  always_comb begin
    opq_s = {NUM_LAYERS{1'b0}};
    for (int i = 0; i < NUM_LAYERS; i++) begin
      opq_s[i] = bus.layer_enable[i] &&
                 (bus.layer_color[i*COLOR_W +: COLOR_W] != TRANSPARENT);
    end
  end

  // Group membership is resolved against the masks seen at sampling time.
  assign active_s = (bus.colPos < H_LIM_C) && (bus.rowPos < V_LIM_C);
  assign grp_a_s  = |(opq_s & bus.mask_a);
  assign grp_b_s  = |(opq_s & bus.mask_b);

  // Stage 1: capture raster position, syncs, layer data and the per-pixel classification.
  always_ff @(posedge clk) begin
    if (reset) begin
      col1_r   <= 10'd0;
      row1_r   <= 10'd0;
      hs1_r    <= 1'b1;
      vs1_r    <= 1'b1;
      lc1_r    <= {(NUM_LAYERS*COLOR_W){1'b0}};
      opq1_r   <= {NUM_LAYERS{1'b0}};
      act1_r   <= 1'b0;
      grp_a1_r <= 1'b0;
      grp_b1_r <= 1'b0;
    end else begin
      col1_r   <= bus.colPos;
      row1_r   <= bus.rowPos;
      hs1_r    <= bus.hsync_in;
      vs1_r    <= bus.vsync_in;
      lc1_r    <= bus.layer_color;
      opq1_r   <= opq_s;
      act1_r   <= active_s;
      grp_a1_r <= grp_a_s;
      grp_b1_r <= grp_b_s;
    end
  end

  // The first blanking line start is never active, so a hit can never share its cycle.
  assign hit_s       = act1_r && grp_a1_r && grp_b1_r;
  assign frame_end_s = (row1_r == V_LIM_C) && (col1_r == 10'd0);

  prio_select #(
    .NUM_LAYERS (NUM_LAYERS),
    .COLOR_W    (COLOR_W)
  ) u_prio_select (
    .opq_s    (opq1_r),
    .colors_s (lc1_r),
    .bg_s     (BG_COLOR),
    .pixel_s  (sel_s)
  );

  // Stage 2: blanking is forced black; syncs leave with the colour they arrived with.
  always_ff @(posedge clk) begin
    if (reset) begin
      color_r <= {COLOR_W{1'b0}};
      hs2_r   <= 1'b1;
      vs2_r   <= 1'b1;
    end else begin
      color_r <= act1_r ? sel_s : BLANK_C;
      hs2_r   <= hs1_r;
      vs2_r   <= vs1_r;
    end
  end

  // Sticky overlap tracking: remember the first hit, publish it at frame end.
  always_ff @(posedge clk) begin
    if (reset) begin
      sticky_r     <= 1'b0;
      pend_x_r     <= 10'd0;
      pend_y_r     <= 10'd0;
      collision_r  <= 1'b0;
      frame_done_r <= 1'b0;
      coll_x_r     <= 10'd0;
      coll_y_r     <= 10'd0;
    end else begin
      frame_done_r <= frame_end_s;
      collision_r  <= frame_end_s && sticky_r;
      if (frame_end_s) begin
        if (sticky_r) begin
          coll_x_r <= pend_x_r;
          coll_y_r <= pend_y_r;
          sticky_r <= 1'b0;
        end else begin
          coll_x_r <= coll_x_r;
          coll_y_r <= coll_y_r;
          sticky_r <= sticky_r;
        end
      end else if (hit_s && !sticky_r) begin
        sticky_r <= 1'b1;
        pend_x_r <= col1_r;
        pend_y_r <= row1_r;
      end else begin
        sticky_r <= sticky_r;
        pend_x_r <= pend_x_r;
        pend_y_r <= pend_y_r;
      end
    end
  end

  assign bus.color       = color_r;
  assign bus.HSYNC       = hs2_r;
  assign bus.VSYNC       = vs2_r;
  assign bus.collision   = collision_r;
  assign bus.frame_done  = frame_done_r;
  assign bus.collision_x = coll_x_r;
  assign bus.collision_y = coll_y_r;

endmodule

// File: doc/layer_compositor.md
Name: layer_compositor

Overview:
Parametrised, pipelined successor to the fixed frog/grid/background priority mux in the game top level. Merges NUM_LAYERS sprite/tile colour layers into one VGA pixel with a fixed 2-cycle latency, and delays HSYNC/VSYNC to match. Also detects per-frame overlap between two layer groups (e.g. frog vs. cars), replacing the tied-off collision signal feeding the frog block.

Parameters:
NUM_LAYERS, 4, number of input layers; index 0 = highest priority
COLOR_W, 6, colour width per layer (RRGGBB)
TRANSPARENT, 6'b000000, layer value treated as "no pixel"
BG_COLOR, 6'b000000, output when every enabled layer is transparent
H_ACTIVE, 640, visible columns
V_ACTIVE, 480, visible rows

Ports:
clk  in  1  pixel clock (25.1 MHz)
reset  in  1  synchronous, active-high
colPos  in  10  current column from vga
rowPos  in  10  current row from vga
hsync_in  in  1  HSYNC from vga, aligned with colPos/rowPos
vsync_in  in  1  VSYNC from vga
layer_color  in  NUM_LAYERS*COLOR_W  packed layer colours; layer i at bits [i*COLOR_W +: COLOR_W]
layer_enable  in  NUM_LAYERS  per-layer enable; disabled layer counts as transparent
mask_a  in  NUM_LAYERS  layers forming collision group A (frog)
mask_b  in  NUM_LAYERS  layers forming collision group B (obstacles)
color  out  COLOR_W  composited pixel
HSYNC  out  1  hsync_in delayed 2 cycles
VSYNC  out  1  vsync_in delayed 2 cycles
collision  out  1  1-cycle pulse at frame end if any overlap occurred in that frame
collision_x  out  10  column of first overlapping pixel of last colliding frame
collision_y  out  10  row of first overlapping pixel of last colliding frame
frame_done  out  1  1-cycle pulse at frame end, every frame

Behaviour:
- Reset (synchronous, active-high, priority over all other activity): color=0, HSYNC=1, VSYNC=1, collision=0, frame_done=0, collision_x=0, collision_y=0, pipeline regs cleared (syncs to 1), sticky flag cleared. Reset mid-frame discards the partial frame; no collision/frame_done pulse for that frame.
- Stage 1 (cycle N+1): register colPos, rowPos, syncs, layer_color, and opaque vector opq[i] = layer_enable[i] && layer_color[i] != TRANSPARENT; active = colPos<H_ACTIVE && rowPos<V_ACTIVE.
- Stage 2 (cycle N+2): color = layer of lowest index with opq set; BG_COLOR if none; 0 when not active (blanking must be black). HSYNC/VSYNC = stage-1 syncs. Total latency exactly 2 cycles for colour and syncs.
- Overlap at stage 1: hit = active && |(opq & mask_a) && |(opq & mask_b). A single layer present in both masks counts for both groups.
- Sticky flag: set on first hit in frame; on that same cycle capture stage-1 colPos/rowPos into pending_x/pending_y. Later hits in the frame do not recapture.
- Frame end event: stage-1 rowPos==V_ACTIVE && colPos==0 (first blanking line). On that cycle: frame_done pulses 1 cycle; if sticky set, collision pulses, collision_x/y load pending_x/pending_y, and sticky clears. Else collision_x/y hold. Frame-end sample is never active, so hit and frame end never coincide.
- Pulses are registered outputs, asserted in the cycle after the stage-1 frame-end sample.
- mask/enable changes take effect at stage-1 sampling; no frame-boundary shadowing.
- Widths: coordinate compares unsigned 10-bit; NUM_LAYERS >= 1; COLOR_W >= 1.

Decomposition:
- Package frogger_pkg: COLOR_W, TRANSPARENT, BLACK, H_ACTIVE, V_ACTIVE, and a pixel_t typedef (logic [COLOR_W-1:0]).
- One sub-module: prio_select (combinational lowest-index opaque select, parametrised on NUM_LAYERS, COLOR_W), instantiated in stage 2.

Test Plan:
- Priority: NUM_LAYERS=4, all enabled, colours {0x3F,0x0C,0x30,0x03} at (100,100) -> color=0x3F exactly 2 cycles later. Layer0=TRANSPARENT -> 0x0C.
- Enable and background: layer_enable=4'b0000, BG_COLOR=0x15 -> color=0x15 in active area, 0x00 at colPos=700.
- Sync alignment: toggle hsync_in at an arbitrary cycle -> HSYNC toggles exactly 2 cycles later. During reset -> HSYNC=VSYNC=1.
- Collision: mask_a=0001, mask_b=0110. Layer0 and layer2 opaque only at (320,448)-(351,479) -> frame_done and collision pulse after row 480 col 0, collision_x=320, collision_y=448.
- No overlap: same masks, layer0 and layer2 disjoint -> frame_done pulses, collision=0, collision_x/y retain prior values (320,448).
- Reset mid-frame: overlap at row 10, reset at row 200, released -> no collision pulse at that frame end; sticky clear, collision_x/y=0.
